// File: rtl/timer_counter.sv
// Memory-mapped timer/counter (TC, device 0): CTRL/PRESET/COUNT registers, four-state
// count FSM and registered interrupt request. Optional prescaler under TC_PRESCALE_EN.
module timer_counter #(
   parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sel,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [3:0]  be,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        irq
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CNT = 2'd2, INT = 2'd3} state_t;

   state_t      state_r, state_s;
   logic [3:0]  ctrl_r, ctrl_s;
   logic [31:0] preset_r, preset_s;
   logic [31:0] count_r, count_s;
   logic        irq_flag_r, irq_flag_s;
   logic        irq_r;
   logic        wr_s;
   logic        tick_s;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be_v);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = be_v[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      end
      return res;
   endfunction

   assign wr_s = sel & we;

`ifdef TC_PRESCALE_EN
   logic [15:0] prescale_r, prescale_s;
   logic [15:0] div_r, div_s;

   // Divider advances only while actively counting; a match produces one count tick.
   always_comb begin
      tick_s     = (div_r == prescale_r);
      prescale_s = prescale_r;
      if (wr_s && addr == 2'd3) begin
         prescale_s[15:8] = be[1] ? wd[15:8] : prescale_r[15:8];
         prescale_s[7:0]  = be[0] ? wd[7:0]  : prescale_r[7:0];
      end else begin
         prescale_s = prescale_r;
      end
      if (state_r == CNT && ctrl_r[0]) begin
         div_s = tick_s ? 16'd0 : div_r + 16'd1;
      end else begin
         div_s = 16'd0;
      end
   end

   // Prescaler registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prescale_r <= 16'd0;
         div_r      <= 16'd0;
      end else begin
         prescale_r <= prescale_s;
         div_r      <= div_s;
      end
   end
`else
   assign tick_s = 1'b1;
`endif

   // Next-state and register update logic; a bus CTRL write overrides FSM side effects.
   always_comb begin
      state_s    = state_r;
      ctrl_s     = ctrl_r;
      count_s    = count_r;
      irq_flag_s = irq_flag_r;
      preset_s   = (wr_s && addr == 2'd1) ? merge_bytes(preset_r, wd, be) : preset_r;
      case (state_r)
         IDLE: begin
            if (ctrl_r[0]) state_s = LOAD;
            else           state_s = IDLE;
         end
         LOAD: begin
            count_s = preset_r;
            state_s = CNT;
         end
         CNT: begin
            if (!ctrl_r[0]) begin
               state_s = IDLE;
            end else if (tick_s) begin
               if (count_r != 32'd0) begin
                  count_s = count_r - 32'd1;
               end else begin
                  state_s    = INT;
                  irq_flag_s = 1'b1;
               end
            end else begin
               state_s = CNT;
            end
         end
         INT: begin
            // Only MODE 01 auto-reloads; every other mode is one-shot.
            if (ctrl_r[2:1] == 2'b01) irq_flag_s = 1'b0;
            else                      ctrl_s[0]  = 1'b0;
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      if (wr_s && addr == 2'd0) begin
         ctrl_s     = be[0] ? wd[3:0] : ctrl_r;
         irq_flag_s = 1'b0;
      end else begin
         ctrl_s = ctrl_s;
      end
   end

   // State and datapath registers; irq is registered from the next flag and mask.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         ctrl_r     <= 4'd0;
         preset_r   <= RESET_PRESET;
         count_r    <= 32'd0;
         irq_flag_r <= 1'b0;
         irq_r      <= 1'b0;
      end else begin
         state_r    <= state_s;
         ctrl_r     <= ctrl_s;
         preset_r   <= preset_s;
         count_r    <= count_s;
         irq_flag_r <= irq_flag_s;
         irq_r      <= irq_flag_s & ctrl_s[3];
      end
   end

   // Combinational read mux, zero when not selected.
   always_comb begin
      rd = 32'd0;
      if (sel) begin
         case (addr)
            2'd0:    rd = {28'd0, ctrl_r};
            2'd1:    rd = preset_r;
            2'd2:    rd = count_r;
`ifdef TC_PRESCALE_EN
            2'd3:    rd = {16'd0, prescale_r};
`endif
            default: rd = 32'd0;
         endcase
      end else begin
         rd = 32'd0;
      end
   end

   assign irq = irq_r;

endmodule

// File: tb/tb_timer_counter.sv
// Randomized self-checking bench for timer_counter; expected values come from a
// closed-form timeline model (cycles since the enabling write) and a register array.
module tb_timer_counter;

   localparam logic [31:0] RP = 32'hCAFE_0005;

   logic        clk;
   logic        reset_n;
   logic        sel;
   logic        we;
   logic [1:0]  addr;
   logic [3:0]  be;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        irq;

   int checks = 0;
   int errors = 0;

   timer_counter #(.RESET_PRESET(RP)) dut (
      .clk(clk), .reset_n(reset_n), .sel(sel), .we(we), .addr(addr),
      .be(be), .wd(wd), .rd(rd), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; we = 1'b1; addr = a; be = b; wd = d;
      @(posedge clk);
      #1;
      we = 1'b0; be = 4'h0;
   endtask

   task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
      sel = 1'b1; addr = a;
      #1;
      v = rd;
   endtask

   // Assert reset asynchronously and check values before any clock edge.
   task automatic reset_check();
      logic [31:0] v;
      #1;
      reset_n = 1'b0;
      rd_reg(2'd0, v); check_eq("rst_ctrl", v, 32'd0);
      rd_reg(2'd1, v); check_eq("rst_preset", v, RP);
      rd_reg(2'd2, v); check_eq("rst_count", v, 32'd0);
      check_eq("rst_irq", {31'd0, irq}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Enable the timer and compare every cycle against the arithmetic timeline.
   task automatic run_timeline(input int p, input int mode, input int im, input int s,
                               input bit clear_after);
      int ti, len, u, en;
      logic [31:0] v, exp_cnt;
      logic exp_irq;
      bit auto_m;
      reset_check();
      bus_wr(2'd1, 4'hF, p);
`ifdef TC_PRESCALE_EN
      bus_wr(2'd3, 4'hF, s);
`endif
      auto_m = (mode == 1);
      ti  = 2 + (p + 1) * (s + 1);
      len = auto_m ? 2 * ti + 4 : ti + 3;
      bus_wr(2'd0, 4'h1, {28'd0, im[0], mode[1:0], 1'b1});
      for (int t = 0; t <= len; t++) begin
         if (t > 0) begin
            @(posedge clk);
            #1;
         end
         u = auto_m ? t % (ti + 1) : t;
         exp_cnt = (u >= 2 && u < ti) ? p - (u - 2) / (s + 1) : 0;
         exp_irq = auto_m ? (u == ti) && im[0] : (t >= ti) && im[0];
         en = auto_m ? 1 : (t <= ti);
         check_eq("irq", {31'd0, irq}, {31'd0, exp_irq});
         rd_reg(2'd2, v); check_eq("count", v, exp_cnt);
         rd_reg(2'd0, v); check_eq("ctrl", v, {28'd0, im[0], mode[1:0], en[0]});
      end
      if (clear_after) begin
         bus_wr(2'd0, 4'h1, 32'd0);
         check_eq("irq_clear", {31'd0, irq}, 32'd0);
         rd_reg(2'd0, v); check_eq("ctrl_clear", v, 32'd0);
      end
   endtask

   initial begin
      logic [31:0] v, d, nv;
      logic [31:0] mreg [4];
      logic [31:0] mask [4];
      logic [1:0]  a;
      logic [3:0]  b;
      int p, mode, im, s;

      clk = 1'b0; reset_n = 1'b0; sel = 1'b0; we = 1'b0;
      addr = 2'd1; be = 4'h0; wd = 32'd0;
      #23;
      check_eq("rd_unsel", rd, 32'd0);
      rd_reg(2'd1, v); check_eq("init_preset", v, RP);
      rd_reg(2'd3, v); check_eq("init_idx3", v, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Random byte-enable register writes against an array model; EN kept low.
      mreg[0] = 32'd0; mreg[1] = RP; mreg[2] = 32'd0; mreg[3] = 32'd0;
      mask[0] = 32'h0000_000F; mask[1] = 32'hFFFF_FFFF; mask[2] = 32'd0;
`ifdef TC_PRESCALE_EN
      mask[3] = 32'h0000_FFFF;
`else
      mask[3] = 32'd0;
`endif
      for (int k = 0; k < 16; k++) begin
         a = 2'($urandom_range(0, 3));
         b = 4'($urandom);
         d = $urandom;
         if (a == 2'd0) d[0] = 1'b0;
         bus_wr(a, b, d);
         nv = mreg[a];
         for (int i = 0; i < 4; i++) if (b[i]) nv[8*i +: 8] = d[8*i +: 8];
         mreg[a] = nv & mask[a];
         rd_reg(a, v); check_eq("reg_rw", v, mreg[a]);
         check_eq("reg_irq", {31'd0, irq}, 32'd0);
      end

      bus_wr(2'd1, 4'hF, 32'h1122_3344);
      bus_wr(2'd1, 4'b0010, 32'h0000_AB00);
      rd_reg(2'd1, v); check_eq("preset_be", v, 32'h1122_AB44);

      run_timeline(3, 0, 1, 0, 1'b1);
      run_timeline(2, 1, 1, 0, 1'b0);
      run_timeline(4, 0, 0, 0, 1'b0);
      run_timeline(5, 2, 1, 0, 1'b0);
      run_timeline(0, 0, 1, 0, 1'b0);
`ifdef TC_PRESCALE_EN
      run_timeline(2, 0, 1, 1, 1'b0);
`endif
      for (int k = 0; k < 6; k++) begin
         p = $urandom_range(0, 6);
         mode = $urandom_range(0, 3);
         im = $urandom_range(0, 1);
`ifdef TC_PRESCALE_EN
         s = $urandom_range(0, 2);
`else
         s = 0;
`endif
         run_timeline(p, mode, im, s, k[0]);
      end

      // Pause: count after edge E6 is 10-4=6, clearing EN at E7 leaves 5 frozen.
      reset_check();
      bus_wr(2'd1, 4'hF, 32'd10);
      bus_wr(2'd0, 4'h1, 32'd1);
      repeat (6) @(posedge clk);
      #1;
      rd_reg(2'd2, v); check_eq("pause_pre", v, 32'd6);
      bus_wr(2'd0, 4'h1, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rd_reg(2'd2, v); check_eq("pause_hold", v, 32'd5);
      bus_wr(2'd2, 4'hF, 32'hFFFF_FFFF);
      repeat (2) @(posedge clk);
      #1;
      rd_reg(2'd2, v); check_eq("count_ro", v, 32'd5);
      check_eq("pause_irq", {31'd0, irq}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
